mainband_pattern_comparator: RTL and testbench
==============================================

MAINBAND_PATTERN_COMPARATOR -- requirements
Module: mainband_pattern_comparator

Interface
REQ-001 Parameter NUM_LANES, default 16, number of mainband data lanes compared.
REQ-002 Parameter ERR_CNT_W, default 12, width of each per-lane saturating error counter.
REQ-003 Parameter LFSR_SEED, default 23'h1DBFBC, reference LFSR load value.
REQ-004 The block SHALL have one clock and synchronous active-high reset: i_clk  in  1  rising-edge clock; i_rst  in  1  synchronous active-high reset.
REQ-005 i_mainband_pattern_comparator_cw  in  2  control word: 00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 NOP.
REQ-006 i_comparison_valid_en  in  1  enables valid-lane pattern check (valvref point test).
REQ-007 i_lane_data  in  NUM_LANES  received data, one bit per lane per beat.
REQ-008 i_data_valid  in  1  beat qualifier for i_lane_data and i_valid_lane.
REQ-009 i_valid_lane  in  1  received valid-lane bit.
REQ-010 i_error_threshold  in  ERR_CNT_W  max error count still reported as pass.
REQ-011 o_comparison_results  out  NUM_LANES  per-lane pass (1) / fail (0).
REQ-012 o_valid_lane_result  out  1  valid-lane pass (1) / fail (0).
REQ-013 o_aggregate_errors  out  16  saturating sum of all data-lane errors.
REQ-014 o_results_valid  out  1  one-cycle pulse, results updated.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, COMPARE, FREEZE, REPORT; state register updated every cycle from cw sampled that cycle.
REQ-016 cw=01 from any state -> CLEAR; cw=10 -> COMPARE; cw=11 -> FREEZE; cw=00 from COMPARE or FREEZE -> REPORT, from REPORT/IDLE/CLEAR -> IDLE.
REQ-017 REPORT SHALL last exactly one cycle, then IDLE (or CLEAR/COMPARE/FREEZE per cw).
REQ-018 CLEAR: LFSR <= LFSR_SEED, all error counters <= 0, aggregate <= 0, valid-pattern phase <= 0, results <= 0.
REQ-019 Reference LFSR: 23-bit state S; one step f = S[22]^S[20]^S[15]^S[7]^S[4]^S[1], S <= {S[21:0], f}.
REQ-020 Expected data word E SHALL equal S[22:7] (lane i expects E[i]); on each COMPARE-state beat (i_data_valid=1) S advances 16 steps in one cycle.
REQ-021 COMPARE beat: lane i error when i_lane_data[i] != E[i]; counter i increments next edge, saturates at 2^ERR_CNT_W-1 (no wrap).
REQ-022 Aggregate SHALL add the popcount of the beat's mismatch vector each beat, saturating at 16'hFFFF.
REQ-023 Valid pattern: 3-bit phase counter advancing each COMPARE beat; expected valid bit = 1 for phase 0-3, 0 for 4-7; wraps 7->0.
REQ-024 Valid-lane error counter (ERR_CNT_W, saturating) increments on mismatch only when i_comparison_valid_en=1.
REQ-025 i_data_valid=0 in COMPARE: no LFSR advance, no phase advance, no counting.
REQ-026 FREEZE and IDLE: LFSR, phase, counters, outputs held; i_lane_data ignored.
REQ-027 REPORT: o_comparison_results[i] <= (cnt[i] <= i_error_threshold); o_valid_lane_result <= (vcnt <= i_error_threshold), forced 1 when i_comparison_valid_en=0; o_results_valid pulses high this cycle.
REQ-028 Latency: last COMPARE beat at cycle t with cw=00 at t+1 -> REPORT at t+1 edge, results and pulse visible cycle t+2; final beat included.
REQ-029 Results SHALL hold until next REPORT, CLEAR, or reset.
REQ-030 cw=01 and i_data_valid=1 same cycle: clear wins, beat discarded.
REQ-031 Threshold sampled only in REPORT; changes elsewhere have no effect.

Reset
REQ-032 i_rst=1 at rising edge: state IDLE, S=LFSR_SEED, counters/phase 0, all outputs 0; overrides any cw.
REQ-033 Reset mid-COMPARE SHALL discard accumulated errors; no o_results_valid pulse generated.

Verification
REQ-034 CLEAR, then 64 beats of correct LFSR data + valid pattern 11110000, cw=00, threshold 0 -> o_comparison_results=16'hFFFF, o_valid_lane_result=1, aggregate 0, one pulse.
REQ-035 Same, lane 5 inverted on 3 beats, threshold 2 -> results=16'hFFDF, aggregate 3; threshold 3 rerun -> 16'hFFFF.
REQ-036 All lanes inverted for 5000 beats -> each counter saturates 4095, aggregate 16'hFFFF, results 16'h0000 with threshold 4094.
REQ-037 Beats with i_data_valid=0 and FREEZE interleaved mid-pattern -> results identical to uninterrupted run.
REQ-038 i_rst asserted mid-COMPARE, then cw=00 -> no pulse, outputs 0; CLEAR+rerun -> correct results.

Source files
------------

// File: rtl/mainband_pattern_comparator_if.sv
// Mainband pattern comparator bus: control word, lane beats, threshold in;
// per-lane / valid-lane pass flags, aggregate error count, result pulse out.
interface mainband_pattern_comparator_if #(
  parameter int NUM_LANES = 16,
  parameter int ERR_CNT_W = 12
);
  // Control word: 00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 NOP.
  logic [1:0]           i_mainband_pattern_comparator_cw;
  // Enables checking of the valid lane against its pattern.
  logic                 i_comparison_valid_en;
  // One received bit per data lane per beat.
  logic [NUM_LANES-1:0] i_lane_data;
  // Beat qualifier for i_lane_data and i_valid_lane.
  logic                 i_data_valid;
  // Received valid-lane bit.
  logic                 i_valid_lane;
  // Largest error count still reported as a pass.
  logic [ERR_CNT_W-1:0] i_error_threshold;
  // Per-lane pass (1) / fail (0).
  logic [NUM_LANES-1:0] o_comparison_results;
  // Valid-lane pass (1) / fail (0).
  logic                 o_valid_lane_result;
  // Saturating sum of all data-lane errors.
  logic [15:0]          o_aggregate_errors;
  // One-cycle pulse marking a results update.
  logic                 o_results_valid;

  // master: the side that drives control and lane data.
  modport master (
    output i_mainband_pattern_comparator_cw,
    output i_comparison_valid_en,
    output i_lane_data,
    output i_data_valid,
    output i_valid_lane,
    output i_error_threshold,
    input  o_comparison_results,
    input  o_valid_lane_result,
    input  o_aggregate_errors,
    input  o_results_valid
  );

  // slave: the comparator itself.
  modport slave (
    input  i_mainband_pattern_comparator_cw,
    input  i_comparison_valid_en,
    input  i_lane_data,
    input  i_data_valid,
    input  i_valid_lane,
    input  i_error_threshold,
    output o_comparison_results,
    output o_valid_lane_result,
    output o_aggregate_errors,
    output o_results_valid
  );
endinterface

// File: rtl/mainband_pattern_comparator.sv
// Mainband pattern comparator: checks received lane beats against a 23-bit
// reference LFSR (16 steps per beat) and the valid lane against 11110000.
// Ports: i_clk, i_rst (sync, active high), bus (slave modport) carrying the
// control word, lane beats, threshold and the pass/fail results.
module mainband_pattern_comparator #(
  parameter int          NUM_LANES = 16,
  parameter int          ERR_CNT_W = 12,
  parameter logic [22:0] LFSR_SEED = 23'h1DBFBC
) (
  input logic                          i_clk,
  input logic                          i_rst,
  mainband_pattern_comparator_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COMPARE,
    ST_FREEZE,
    ST_REPORT
  } state_e;

  localparam logic [1:0] CW_IDLE  = 2'b00;
  localparam logic [1:0] CW_CLEAR = 2'b01;
  localparam logic [1:0] CW_LFSR  = 2'b10;
  localparam logic [1:0] CW_NOP   = 2'b11;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_e state_q, state_d;

  logic do_clear;
  logic do_beat;
  logic do_report;

  logic [22:0]          s_q, s_d;
  logic [2:0]           phase_q, phase_d;
  logic [ERR_CNT_W-1:0] cnt_q [NUM_LANES];
  logic [ERR_CNT_W-1:0] cnt_d [NUM_LANES];
  logic [ERR_CNT_W-1:0] vcnt_q, vcnt_d;
  logic [15:0]          agg_q, agg_d;
  logic [NUM_LANES-1:0] res_q, res_d;
  logic                 vres_q, vres_d;
  logic                 rv_q, rv_d;

  logic [NUM_LANES-1:0] exp_w;
  logic [NUM_LANES-1:0] mis;
  logic                 vexp;
  logic                 vmis;
  logic [16:0]          pop;
  logic [16:0]          agg_sum;

  // Sixteen serial LFSR steps collapsed into one cycle.
  function automatic logic [22:0] lfsr16(input logic [22:0] s);
    logic [22:0] t;
    logic        f;
    t = s;
    for (int k = 0; k < 16; k++) begin
      f = t[22] ^ t[20] ^ t[15] ^ t[7] ^ t[4] ^ t[1];
      t = {t[21:0], f};
    end
    return t;
  endfunction

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the control word sampled this cycle.
  always_comb begin
    state_d = state_q;
    unique case (bus.i_mainband_pattern_comparator_cw)
      CW_CLEAR: state_d = ST_CLEAR;
      CW_LFSR:  state_d = ST_COMPARE;
      CW_NOP:   state_d = ST_FREEZE;
      CW_IDLE: begin
        if (state_q == ST_COMPARE || state_q == ST_FREEZE) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control decode. Clear and report act on the edge that enters the
  // state, so results appear during the REPORT cycle alongside the pulse.
  // A clear request always discards a beat offered in the same cycle.
  always_comb begin
    do_clear  = (state_d == ST_CLEAR);
    do_report = (state_d == ST_REPORT);
    do_beat   = (state_q == ST_COMPARE) &&
                bus.i_data_valid && !do_clear;
  end

  // Datapath next-state.
  always_comb begin
    exp_w = NUM_LANES'(s_q[22:7]);
    mis   = (bus.i_lane_data ^ exp_w) & {NUM_LANES{do_beat}};
    // Valid pattern is 1111_0000 over the phase counter.
    vexp  = ~phase_q[2];
    vmis  = do_beat && bus.i_comparison_valid_en &&
            (bus.i_valid_lane != vexp);

    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop = pop + 17'(mis[i]);
    end
    agg_sum = {1'b0, agg_q} + pop;

    s_d     = s_q;
    phase_d = phase_q;
    vcnt_d  = vcnt_q;
    agg_d   = agg_q;
    res_d   = res_q;
    vres_d  = vres_q;
    rv_d    = do_report;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (do_clear) begin
      s_d     = LFSR_SEED;
      phase_d = '0;
      vcnt_d  = '0;
      agg_d   = '0;
      res_d   = '0;
      vres_d  = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      if (do_beat) begin
        s_d     = lfsr16(s_q);
        phase_d = phase_q + 3'd1;
        agg_d   = agg_sum[16] ? 16'hFFFF : agg_sum[15:0];
        if (vmis && vcnt_q != CNT_MAX) begin
          vcnt_d = vcnt_q + 1'b1;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
          if (mis[i] && cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
      // Use next-state counts so a beat in the same cycle is included.
      if (do_report) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          res_d[i] = (cnt_d[i] <= bus.i_error_threshold);
        end
        vres_d = !bus.i_comparison_valid_en ||
                 (vcnt_d <= bus.i_error_threshold);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_q     <= LFSR_SEED;
      phase_q <= '0;
      vcnt_q  <= '0;
      agg_q   <= '0;
      res_q   <= '0;
      vres_q  <= 1'b0;
      rv_q    <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s_q     <= s_d;
      phase_q <= phase_d;
      vcnt_q  <= vcnt_d;
      agg_q   <= agg_d;
      res_q   <= res_d;
      vres_q  <= vres_d;
      rv_q    <= rv_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.o_comparison_results = res_q;
  assign bus.o_valid_lane_result  = vres_q;
  assign bus.o_aggregate_errors   = agg_q;
  assign bus.o_results_valid      = rv_q;

endmodule

// File: tb/tb_mainband_pattern_comparator.sv
// Self-checking bench for mainband_pattern_comparator: randomized and
// directed beats checked against a bit-stream reference model.
module tb_mainband_pattern_comparator;

  localparam int SAT = 4095;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mainband_pattern_comparator_if bus ();

  mainband_pattern_comparator #(
    .NUM_LANES(16),
    .ERR_CNT_W(12),
    .LFSR_SEED(23'h1DBFBC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the LFSR viewed as one long bit stream x[], where beat b
  // expects lane 15 down to lane 0 to carry x[16b] .. x[16b+15].
  bit xs[];
  int m_cnt[16];
  int m_vcnt;
  int m_agg;
  int m_phase;
  int m_beat;

  task automatic gen_stream;
    logic [22:0] seed;
    seed = 23'h1DBFBC;
    xs = new[16 * 5100 + 64];
    for (int j = 0; j < 23; j++) xs[j] = seed[22-j];
    for (int n = 23; n < xs.size(); n++)
      xs[n] = xs[n-23] ^ xs[n-21] ^ xs[n-16] ^ xs[n-8] ^ xs[n-5] ^ xs[n-2];
  endtask

  function automatic logic [15:0] exp_word(input int b);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = xs[16*b + 15 - i];
    return w;
  endfunction

  task automatic m_clear;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_vcnt = 0;
    m_agg = 0;
    m_phase = 0;
    m_beat = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_compare;
    bus.i_mainband_pattern_comparator_cw = 2'b01;
    bus.i_data_valid = 1'b0;
    tick();
    m_clear();
    bus.i_mainband_pattern_comparator_cw = 2'b10;
    tick();
  endtask

  task automatic beat(input logic [15:0] inv, input bit vflip);
    int pc;
    pc = 0;
    bus.i_mainband_pattern_comparator_cw = 2'b10;
    bus.i_data_valid = 1'b1;
    bus.i_lane_data = exp_word(m_beat) ^ inv;
    bus.i_valid_lane = (m_phase < 4) ^ vflip;
    bus.i_error_threshold = 12'($urandom);
    tick();
    bus.i_data_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (inv[i]) begin
        pc++;
        if (m_cnt[i] < SAT) m_cnt[i]++;
      end
    end
    m_agg = (m_agg + pc > 65535) ? 65535 : m_agg + pc;
    if (vflip && bus.i_comparison_valid_en && m_vcnt < SAT) m_vcnt++;
    m_phase = (m_phase + 1) % 8;
    m_beat++;
  endtask

  task automatic gap;
    bus.i_mainband_pattern_comparator_cw = 2'b10;
    bus.i_data_valid = 1'b0;
    bus.i_lane_data = 16'($urandom);
    bus.i_valid_lane = 1'($urandom);
    tick();
  endtask

  task automatic freeze_mid;
    bus.i_mainband_pattern_comparator_cw = 2'b11;
    bus.i_data_valid = 1'b0;
    tick();
    bus.i_data_valid = 1'b1;
    bus.i_lane_data = 16'($urandom);
    tick();
    bus.i_mainband_pattern_comparator_cw = 2'b10;
    bus.i_data_valid = 1'b0;
    tick();
  endtask

  // Issue cw=00 from COMPARE/FREEZE, check the REPORT cycle and the
  // following IDLE cycle against the model.
  task automatic do_report(input string nm, input int thr);
    logic [15:0] er;
    bit ev;
    bus.i_mainband_pattern_comparator_cw = 2'b00;
    bus.i_data_valid = 1'b0;
    bus.i_error_threshold = 12'(thr);
    tick();
    for (int i = 0; i < 16; i++) er[i] = (m_cnt[i] <= thr);
    ev = !bus.i_comparison_valid_en || (m_vcnt <= thr);
    checks++;
    if (bus.o_results_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s.pulse got %b want 1", nm, bus.o_results_valid);
    end
    checks++;
    if (bus.o_comparison_results !== er) begin
      errors++;
      $display("FAIL %s.res got %h want %h", nm,
               bus.o_comparison_results, er);
    end
    checks++;
    if (bus.o_valid_lane_result !== ev) begin
      errors++;
      $display("FAIL %s.vres got %b want %b", nm,
               bus.o_valid_lane_result, ev);
    end
    checks++;
    if (bus.o_aggregate_errors !== 16'(m_agg)) begin
      errors++;
      $display("FAIL %s.agg got %h want %h", nm,
               bus.o_aggregate_errors, 16'(m_agg));
    end
    bus.i_error_threshold = 12'($urandom);
    tick();
    checks++;
    if (bus.o_results_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s.pulse_end got %b want 0", nm, bus.o_results_valid);
    end
    checks++;
    if (bus.o_comparison_results !== er) begin
      errors++;
      $display("FAIL %s.hold got %h want %h", nm,
               bus.o_comparison_results, er);
    end
  endtask

  task automatic freeze_report(input string nm, input int thr);
    bus.i_mainband_pattern_comparator_cw = 2'b11;
    bus.i_data_valid = 1'b0;
    tick();
    do_report(nm, thr);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_mainband_pattern_comparator_cw = 2'b10;
    bus.i_data_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.o_results_valid !== 1'b0 || bus.o_valid_lane_result !== 1'b0) begin
      errors++;
      $display("FAIL reset.flags got %b%b want 00",
               bus.o_results_valid, bus.o_valid_lane_result);
    end
    checks++;
    if (bus.o_comparison_results !== 16'h0 || bus.o_aggregate_errors !== 16'h0) begin
      errors++;
      $display("FAIL reset.vec got %h/%h want 0/0",
               bus.o_comparison_results, bus.o_aggregate_errors);
    end
    bus.i_data_valid = 1'b0;
    bus.i_mainband_pattern_comparator_cw = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean;
    bus.i_comparison_valid_en = 1'b1;
    start_compare();
    for (int b = 0; b < 64; b++) beat(16'h0, 1'b0);
    do_report("clean", 0);
  endtask

  task automatic test_lane5;
    start_compare();
    checks++;
    if (bus.o_comparison_results !== 16'h0 || bus.o_aggregate_errors !== 16'h0) begin
      errors++;
      $display("FAIL clear.vec got %h/%h want 0/0",
               bus.o_comparison_results, bus.o_aggregate_errors);
    end
    for (int b = 0; b < 64; b++)
      beat((b == 7 || b == 30 || b == 55) ? 16'h0020 : 16'h0, 1'b0);
    do_report("lane5_t2", 2);
    freeze_report("lane5_t3", 3);
  endtask

  task automatic test_valid_en;
    bus.i_comparison_valid_en = 1'b0;
    start_compare();
    for (int b = 0; b < 16; b++) beat(16'h0, 1'b1);
    do_report("ven_off", 0);
    bus.i_comparison_valid_en = 1'b1;
    start_compare();
    for (int b = 0; b < 16; b++) beat(16'h0, (b == 3 || b == 9));
    do_report("ven_t1", 1);
    freeze_report("ven_t2", 2);
  endtask

  task automatic test_clear_wins;
    start_compare();
    for (int b = 0; b < 5; b++) beat(16'hF00F, 1'b1);
    bus.i_mainband_pattern_comparator_cw = 2'b01;
    bus.i_data_valid = 1'b1;
    bus.i_lane_data = ~exp_word(m_beat);
    tick();
    m_clear();
    bus.i_data_valid = 1'b0;
    bus.i_mainband_pattern_comparator_cw = 2'b10;
    tick();
    for (int b = 0; b < 8; b++) beat(16'h0, 1'b0);
    do_report("clear_wins", 0);
  endtask

  task automatic test_interrupted;
    logic [15:0] pat [40];
    for (int b = 0; b < 40; b++)
      pat[b] = (b % 6 == 2) ? 16'(1 << (b % 16)) : 16'h0;
    start_compare();
    for (int b = 0; b < 40; b++) beat(pat[b], (b % 11 == 4));
    do_report("straight", 1);
    start_compare();
    for (int b = 0; b < 40; b++) begin
      if (b % 7 == 3) gap();
      if (b % 13 == 5) freeze_mid();
      beat(pat[b], (b % 11 == 4));
    end
    do_report("interrupted", 1);
  endtask

  task automatic test_reset_mid;
    start_compare();
    for (int b = 0; b < 10; b++) beat(16'h00FF, 1'b1);
    rst = 1'b1;
    bus.i_data_valid = 1'b1;
    tick();
    rst = 1'b0;
    m_clear();
    bus.i_data_valid = 1'b0;
    bus.i_mainband_pattern_comparator_cw = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.o_results_valid !== 1'b0 || bus.o_comparison_results !== 16'h0 ||
          bus.o_aggregate_errors !== 16'h0 || bus.o_valid_lane_result !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid.%0d got %b/%h/%h/%b want 0/0/0/0", k,
                 bus.o_results_valid, bus.o_comparison_results,
                 bus.o_aggregate_errors, bus.o_valid_lane_result);
      end
    end
    start_compare();
    for (int b = 0; b < 16; b++) beat(16'h0, 1'b0);
    do_report("rst_rerun", 0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int n;
      bus.i_comparison_valid_en = 1'($urandom);
      start_compare();
      n = $urandom_range(10, 80);
      for (int b = 0; b < n; b++) begin
        int r;
        logic [15:0] inv;
        r = $urandom % 10;
        if (r == 0) gap();
        else if (r == 1) freeze_mid();
        inv = ($urandom % 3 == 0) ? 16'(1 << ($urandom % 16)) : 16'h0;
        if ($urandom % 9 == 0) inv = inv | 16'($urandom);
        beat(inv, ($urandom % 6 == 0));
      end
      do_report($sformatf("rand%0d", it), $urandom % 6);
    end
  endtask

  task automatic test_saturate;
    bus.i_comparison_valid_en = 1'b1;
    start_compare();
    for (int b = 0; b < 5000; b++) beat(16'hFFFF, 1'b1);
    do_report("sat_4094", 4094);
    freeze_report("sat_4095", 4095);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_mainband_pattern_comparator_cw = 2'b00;
    bus.i_comparison_valid_en = 1'b1;
    bus.i_lane_data = '0;
    bus.i_data_valid = 1'b0;
    bus.i_valid_lane = 1'b0;
    bus.i_error_threshold = '0;
    gen_stream();
    m_clear();
    test_reset();
    test_clean();
    test_lane5();
    test_valid_en();
    test_clear_wins();
    test_interrupted();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
